// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh edge-terminal receiver: packet field
// positions, the broadcast id and the ingress state encoding.
package mesh_pkg;

   localparam logic [3:0] BCST_ID = 4'hF;

   typedef enum logic {IDLE, GAP} rx_state_t;

   // Header fields sit at the top of the packet, so positions track pckg_sz.
   function automatic int nxt_msb(input int sz);  return sz - 1;  endfunction
   function automatic int nxt_lsb(input int sz);  return sz - 8;  endfunction
   function automatic int row_msb(input int sz);  return sz - 9;  endfunction
   function automatic int row_lsb(input int sz);  return sz - 12; endfunction
   function automatic int col_msb(input int sz);  return sz - 13; endfunction
   function automatic int col_lsb(input int sz);  return sz - 16; endfunction
   function automatic int mode_bit(input int sz); return sz - 17; endfunction
   function automatic int pay_msb(input int sz);  return sz - 18; endfunction

endpackage

// File: rtl/mesh_term_rx_if.sv
// Mesh-side pop handshake plus the local valid/ready consumer stream.
interface mesh_term_rx_if #(
   parameter int pckg_sz = 40
);
   logic               pndng_i_in;
   logic [pckg_sz-1:0] data_out_i_in;
   logic               pop;
   logic               rx_valid;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_ready;

   modport slave (
      input  pndng_i_in, data_out_i_in, rx_ready,
      output pop, rx_valid, rx_data
   );

   modport master (
      output pndng_i_in, data_out_i_in, rx_ready,
      input  pop, rx_valid, rx_data
   );
endinterface

// File: rtl/mesh_rx_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy counter that
// separates full from empty. DEPTH must be a power of two, at least 2.
module mesh_rx_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; the empty flag masks stale contents.
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end

endmodule

// File: rtl/mesh_term_rx.sv
// Edge-terminal receiver: drains the mesh output FIFO, optionally filters on
// destination (MESH_RX_DEST_CHECK_EN), buffers and streams to a consumer.
module mesh_term_rx
   import mesh_pkg::*;
#(
   parameter int         pckg_sz    = 40,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [3:0] SELF_ROW   = 4'd0,
   parameter logic [3:0] SELF_COL   = 4'd1,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   mesh_term_rx_if.slave    rx,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   rx_state_t          state;
   logic               full, empty;
   logic               take, dest_ok, push;
   logic [pckg_sz-1:0] head;

   // Full is sampled before this cycle's consumer pop, so ingress never
   // relies on space that is only freed at the same edge.
   assign take   = reset && (state == IDLE) && rx.pndng_i_in && !full;
   assign rx.pop = take;

`ifdef MESH_RX_DEST_CHECK_EN
   logic [3:0] id_row, id_col;
   assign id_row  = rx.data_out_i_in[row_msb(pckg_sz):row_lsb(pckg_sz)];
   assign id_col  = rx.data_out_i_in[col_msb(pckg_sz):col_lsb(pckg_sz)];
   assign dest_ok = ((id_row == SELF_ROW) && (id_col == SELF_COL)) ||
                    ((id_row == BCST_ID)  && (id_col == BCST_ID));

   always_ff @(posedge clk or negedge reset)
      if (!reset)                          err_cnt <= '0;
      else if (take && !dest_ok && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
`else
   assign dest_ok = 1'b1;
   assign err_cnt = '0;
`endif

   assign push = take && dest_ok;

   // The mesh head word may still read as pending right after a pop, so one
   // idle cycle follows every capture.
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else
         case (state)
            IDLE:    if (take) state <= GAP;
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase

   always_ff @(posedge clk or negedge reset)
      if (!reset)                     pkt_cnt <= '0;
      else if (push && pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);

   mesh_rx_fifo #(
      .W     (pckg_sz),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .din   (rx.data_out_i_in),
      .pop   (rx.rx_valid && rx.rx_ready),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign rx.rx_valid = !empty;
   assign rx.rx_data  = head;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Directed bench for mesh_term_rx: a queue models the mesh output FIFO and
// expected values are hand-derived packets and counts.
module tb_mesh_term_rx;
   localparam int W = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pkt_cnt, err_cnt;

   mesh_term_rx_if #(.pckg_sz(W)) bus ();

   mesh_term_rx #(
      .pckg_sz(W), .FIFO_DEPTH(4), .SELF_ROW(4'd0), .SELF_COL(4'd1), .CNT_W(16)
   ) dut (
      .clk     (clk),
      .reset   (rst_n),
      .rx      (bus),
      .pkt_cnt (pkt_cnt),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int         nvec = 0, nerr = 0;
   int         cyc = 0, pops = 0;
   int         exp_pkt = 0, exp_err = 0;
   logic [W-1:0] mq[$];
   logic [W-1:0] got[$];
   int         pop_cyc[$];
   int         rcv_cyc[$];

   task automatic drive_mesh();
      bus.pndng_i_in    = (mq.size() > 0);
      bus.data_out_i_in = (mq.size() > 0) ? mq[0] : '0;
   endtask

   task automatic clear_log();
      pops = 0;
      got.delete();
      pop_cyc.delete();
      rcv_cyc.delete();
   endtask

   // Samples at the falling edge, then advances the mesh model after the rise.
   task automatic tick();
      logic p;
      @(negedge clk);
      p = bus.pop;
      if (p) begin pops++; pop_cyc.push_back(cyc); end
      if (bus.rx_valid && bus.rx_ready) begin
         got.push_back(bus.rx_data);
         rcv_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (p && mq.size() > 0) mq.delete(0);
      drive_mesh();
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.rx_ready = 1'b0;
      mq.push_back(40'h00010000AB);
      drive_mesh();
      #2;
      nvec++; if (bus.pop !== 1'b0) begin nerr++; $display("FAIL reset_pop: got %b want 0", bus.pop); end
      nvec++; if (bus.rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
      nvec++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pkt_cnt, err_cnt); end
      mq.delete();
      drive_mesh();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      clear_log();
      bus.rx_ready = 1'b1;
      mq.push_back(40'h00010000AB);
      drive_mesh();
      repeat (6) tick();
      exp_pkt++;
      nvec++; if (pops !== 1) begin nerr++; $display("FAIL single_pops: got %0d want 1", pops); end
      nvec++; if (got.size() !== 1) begin nerr++; $display("FAIL single_count: got %0d want 1", got.size()); end
      else begin
         nvec++; if (got[0] !== 40'h00010000AB) begin nerr++; $display("FAIL single_data: got %h want 00010000ab", got[0]); end
         nvec++; if (rcv_cyc[0] !== pop_cyc[0] + 1) begin nerr++; $display("FAIL single_latency: got %0d want 1", rcv_cyc[0] - pop_cyc[0]); end
      end
      nvec++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL single_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
   endtask

   task automatic test_misroute();
      clear_log();
      bus.rx_ready = 1'b1;
      mq.push_back(40'h0023000055);
      drive_mesh();
      repeat (6) tick();
      nvec++; if (pops !== 1) begin nerr++; $display("FAIL misroute_pops: got %0d want 1", pops); end
`ifdef MESH_RX_DEST_CHECK_EN
      exp_err++;
      nvec++; if (got.size() !== 0) begin nerr++; $display("FAIL misroute_dropped: got %0d delivered want 0", got.size()); end
`else
      exp_pkt++;
      nvec++; if (got.size() !== 1 || got[0] !== 40'h0023000055) begin nerr++; $display("FAIL nocheck_accept: got %0d packets want 1 of 0023000055", got.size()); end
`endif
      nvec++; if (err_cnt !== 16'(exp_err)) begin nerr++; $display("FAIL misroute_err_cnt: got %0d want %0d", err_cnt, exp_err); end
      nvec++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL misroute_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] pk[6];
      clear_log();
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pk[i] = 40'h0001000010 + 40'(i);
         mq.push_back(pk[i]);
      end
      drive_mesh();
      repeat (14) tick();
      nvec++; if (pops !== 4) begin nerr++; $display("FAIL bp_pops: got %0d want 4", pops); end
      for (int i = 1; i < pop_cyc.size(); i++) begin
         nvec++; if (pop_cyc[i] - pop_cyc[i-1] !== 2) begin nerr++; $display("FAIL bp_spacing: got %0d want 2", pop_cyc[i] - pop_cyc[i-1]); end
      end
      nvec++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== pk[0]) begin nerr++; $display("FAIL bp_hold: got %b/%h want 1/%h", bus.rx_valid, bus.rx_data, pk[0]); end
      nvec++; if (mq.size() !== 2) begin nerr++; $display("FAIL bp_left: got %0d want 2", mq.size()); end
      bus.rx_ready = 1'b1;
      repeat (16) tick();
      exp_pkt += 6;
      nvec++; if (got.size() !== 6) begin nerr++; $display("FAIL bp_count: got %0d want 6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         nvec++; if (got[i] !== pk[i]) begin nerr++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], pk[i]); end
      end
      nvec++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL bp_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
   endtask

   task automatic test_broadcast();
      clear_log();
      bus.rx_ready = 1'b1;
      mq.push_back(40'h00FF000001);
      drive_mesh();
      repeat (6) tick();
      exp_pkt++;
      nvec++; if (got.size() !== 1 || got[0] !== 40'h00FF000001) begin nerr++; $display("FAIL bcast_accept: got %0d packets want 1 of 00ff000001", got.size()); end
      nvec++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL bcast_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
      nvec++; if (err_cnt !== 16'(exp_err)) begin nerr++; $display("FAIL bcast_err_cnt: got %0d want %0d", err_cnt, exp_err); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_log();
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 3; i++) mq.push_back(40'h0001000020 + 40'(i));
      drive_mesh();
      while (pops < 3 && n < 20) begin tick(); n++; end
      nvec++; if (pops !== 3) begin nerr++; $display("FAIL mid_fill: got %0d pops want 3", pops); end
      // Third pop just landed, so the ingress FSM now sits in its gap cycle.
      mq.push_back(40'h00010000C3);
      drive_mesh();
      #2 rst_n = 1'b0;
      #1;
      nvec++; if (bus.rx_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid: got %b want 0", bus.rx_valid); end
      nvec++; if (bus.pop !== 1'b0) begin nerr++; $display("FAIL mid_pop: got %b want 0", bus.pop); end
      nvec++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin nerr++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", pkt_cnt, err_cnt); end
      repeat (2) tick();
      nvec++; if (pops !== 3) begin nerr++; $display("FAIL mid_pop_held: got %0d pops want 3", pops); end
      rst_n        = 1'b1;
      bus.rx_ready = 1'b1;
      exp_pkt = 1; exp_err = 0;
      clear_log();
      repeat (6) tick();
      nvec++; if (got.size() !== 1 || got[0] !== 40'h00010000C3) begin nerr++; $display("FAIL mid_after: got %0d packets want 1 of 00010000c3", got.size()); end
      nvec++; if (pkt_cnt !== 16'(exp_pkt)) begin nerr++; $display("FAIL mid_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); end
   endtask

   initial begin
      bus.pndng_i_in    = 1'b0;
      bus.data_out_i_in = '0;
      bus.rx_ready      = 1'b0;
      test_reset();
      test_single();
      test_misroute();
      test_backpressure();
      test_broadcast();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mesh_term_rx.md
# mesh_term_rx

Synthesizable edge-terminal receiver for the `mesh_gnrtr` router mesh: one instance sits on each external terminal and drains packets that the mesh delivers on `pndng_i_in`/`data_out_i_in`/`pop`. It is the exit-side counterpart of the injecting drivers. Each instance:
- optionally checks the destination row/column against its own terminal position;
- buffers accepted packets in a small FIFO;
- presents them to a local consumer over a valid/ready stream;
- keeps accepted and misrouted packet counts.

## Interface
Parameters:
- `pckg_sz`, 40: packet width in bits.
- `FIFO_DEPTH`, 4: receive buffer depth. Must be a power of two and at least 2.
- `SELF_ROW`, 0: terminal row id, 4 bits.
- `SELF_COL`, 1: terminal column id, 4 bits.
- `CNT_W`, 16: width of the packet counters.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng_i_in`  in  1  mesh output FIFO non-empty. Head word is valid on `data_out_i_in` (first-word-fall-through).
- `data_out_i_in`  in  `pckg_sz`  mesh head packet.
- `pop`  out  1  consume the mesh head packet this cycle.
- `rx_valid`  out  1  buffered packet available.
- `rx_data`  out  `pckg_sz`  buffered head packet, full 40-bit word including header.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `pkt_cnt`  out  `CNT_W`  packets accepted into the buffer.
- `err_cnt`  out  `CNT_W`  misrouted packets dropped.

## Operation
- Packet fields:
  - `Nxt_jump` = [pckg_sz-1 : pckg_sz-8]
  - `id_row` = [pckg_sz-9 : pckg_sz-12]
  - `id_col` = [pckg_sz-13 : pckg_sz-16]
  - `mode` = [pckg_sz-17]
  - payload = [pckg_sz-18 : 0]
- Ingress FSM has two states, `IDLE` and `GAP`.
  - `IDLE`: `pop` = `pndng_i_in` && !`full` (combinational). When `pop`=1, `data_out_i_in` is captured at the same edge and the next state is `GAP`.
  - `GAP`: `pop`=0 for exactly one cycle, because `pndng_i_in` may be stale immediately after a pop. Next state is `IDLE`.
- Destination check applies to each captured packet (see Configuration).
  - match: push to FIFO, `pkt_cnt`++.
  - mismatch: discard, `err_cnt`++.
- Egress: `rx_valid` = !`empty` and `rx_data` = FIFO head. The FIFO pops on `rx_valid` && `rx_ready`.
- `full` means occupancy == `FIFO_DEPTH`. It is evaluated before any consumer pop in the same cycle, so the decision is conservative and the FIFO never overflows.
- Simultaneous push and pop is allowed at any occupancy below full; occupancy is then unchanged.
- Counters saturate at all-ones and never wrap.
- Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. An extra occupancy counter distinguishes full from empty.

## Timing
- Reset (`reset`=0, asynchronous) clears:
  - FSM to `IDLE`
  - FIFO to empty, so `rx_valid`=0
  - `pop`=0 (gated by reset)
  - `pkt_cnt`=0, `err_cnt`=0
  - `rx_data` contents are don't-care while `rx_valid`=0.
- Reset mid-transfer drops all buffered packets. A packet popped on the edge that coincides with reset assertion is lost.
- Latency: a packet popped at edge N is visible with `rx_valid`=1 in the cycle after edge N, i.e. one cycle.
- Peak ingress rate is one packet every 2 cycles. Egress can sustain one packet per cycle.
- While `rx_ready`=0, `rx_data` holds stable and `rx_valid` stays high.
- Counters update at the capture edge.

## Configuration
- Macro: `MESH_RX_DEST_CHECK_EN`.
- Defined:
  - A packet matches if `id_row`==`SELF_ROW` && `id_col`==`SELF_COL`, or if both fields are 4'hF (broadcast).
  - Non-matching packets are dropped and counted in `err_cnt`.
- Undefined:
  - Every captured packet is pushed and counted in `pkt_cnt`.
  - `err_cnt` is tied to 0.
  - No compare logic is synthesized.

## Structure
- Package `mesh_pkg` holds:
  - field MSB/LSB localparams as functions of `pckg_sz`;
  - `BCST_ID` = 4'hF;
  - the ingress state enum `rx_state_t {IDLE, GAP}`.
- Sub-module `mesh_rx_fifo`: parameterized synchronous FIFO with `push`, `pop`, `full`, `empty` and head data. It is instantiated once.

## Test plan
All scenarios use `SELF_ROW`=0, `SELF_COL`=1, `FIFO_DEPTH`=4, built with `MESH_RX_DEST_CHECK_EN` except scenario 5.
1. Single delivery: `pndng_i_in`=1 with 40'h00010000AB for one pop, `rx_ready`=1.
   - `pop` is high for exactly 1 cycle.
   - `rx_valid`=1 with `rx_data`=40'h00010000AB one cycle later.
   - `pkt_cnt`=1.
2. Misroute: deliver 40'h0023000055.
   - Popped, `rx_valid` stays 0.
   - `err_cnt`=1, `pkt_cnt`=0.
3. Backpressure: `rx_ready`=0, `pndng_i_in` held 1 with 6 distinct matching packets.
   - Exactly 4 pops, spaced 2 cycles apart, then `pop` stays 0.
   - With `rx_ready`=1, packets emerge in order, followed by the remaining 2.
4. Broadcast: deliver 40'h00FF000001.
   - Accepted, `pkt_cnt`++.
5. Macro off: deliver 40'h0023000055.
   - Accepted, `rx_data`=40'h0023000055.
   - `err_cnt`=0.
6. Reset mid-stream: assert `reset`=0 with 3 packets buffered and the FSM in `GAP`.
   - Asynchronously `rx_valid`=0, `pop`=0, both counters 0.
   - After release, a new packet is accepted normally.
